// File: rtl/div_pkg.sv
// div_pkg: shared widths, state encoding and counter sizing for seq_div
package div_pkg;
  localparam int WIDTH_A_DEF = 16;
  localparam int WIDTH_B_DEF = 8;
  localparam int CNT_W_DEF = $clog2(WIDTH_A_DEF);
  typedef enum logic {IDLE, WORK} state_t;
  function automatic int cnt_w(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step (shift in a dividend bit, compare, subtract)
module div_step #(
  parameter int WIDTH_B = 8
) (
  input  logic [WIDTH_B:0]   i_rem,
  input  logic               i_bit,
  input  logic [WIDTH_B-1:0] i_div,
  output logic [WIDTH_B:0]   o_rem,
  output logic               o_q
);
  logic [WIDTH_B:0] w_sh;
  always_comb begin
    w_sh = {i_rem[WIDTH_B-1:0], i_bit};
    o_q = w_sh >= {1'b0, i_div};
    o_rem = o_q ? w_sh - {1'b0, i_div} : w_sh;
  end
endmodule

// File: rtl/seq_div.sv
// seq_div: sequential unsigned restoring divider, one quotient bit per clock,
// start/busy handshake shared with the sequential multiplier.
module seq_div
  import div_pkg::*;
#(
  parameter int WIDTH_A = WIDTH_A_DEF,
  parameter int WIDTH_B = WIDTH_B_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH_A-1:0] a_bi,
  input  logic [WIDTH_B-1:0] b_bi,
  input  logic               start_i,
  output logic               busy_o,
  output logic [WIDTH_A-1:0] y_bo,
  output logic [WIDTH_B-1:0] r_bo,
  output logic               div0_o
);
  localparam int CW = cnt_w(WIDTH_A);
  state_t             r_state, w_next;
  logic [WIDTH_A-1:0] r_a, w_a_nxt, r_y;
  logic [WIDTH_B-1:0] r_b, r_r;
  logic [WIDTH_B:0]   r_rem, w_rem;
  logic [CW-1:0]      r_cnt;
  logic               r_div0, w_q, w_last, w_zero;
  div_step #(.WIDTH_B(WIDTH_B)) u_step (
    .i_rem(r_rem),
    .i_bit(r_a[WIDTH_A-1]),
    .i_div(r_b),
    .o_rem(w_rem),
    .o_q  (w_q)
  );
  // quotient bits shift into the vacated LSBs of the dividend register
  always_comb begin
    w_a_nxt = {r_a[WIDTH_A-2:0], w_q};
    w_last = r_cnt == CW'(WIDTH_A - 1);
    w_zero = r_b == '0;
    w_next = (r_state == IDLE) ? (start_i ? WORK : IDLE)
                               : ((w_zero || w_last) ? IDLE : WORK);
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_a <= '0;
      r_b <= '0;
      r_rem <= '0;
      r_cnt <= '0;
      r_y <= '0;
      r_r <= '0;
      r_div0 <= 1'b0;
    end else if (r_state == IDLE) begin
      if (start_i) begin
        r_a <= a_bi;
        r_b <= b_bi;
        r_rem <= '0;
        r_cnt <= '0;
      end
    end else if (w_zero) begin
      r_y <= '1;
      r_r <= r_a[WIDTH_B-1:0];
      r_div0 <= 1'b1;
    end else begin
      r_a <= w_a_nxt;
      r_rem <= w_rem;
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) begin
        r_y <= w_a_nxt;
        r_r <= w_rem[WIDTH_B-1:0];
        r_div0 <= 1'b0;
      end
    end
  end
  assign busy_o = r_state == WORK;
  assign y_bo = r_y;
  assign r_bo = r_r;
  assign div0_o = r_div0;
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed vectors, expected results queued by the driver and
// checked by an independent monitor on each completion.
module tb_seq_div;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a_bi = '0;
  logic [7:0]  b_bi = '0;
  logic        start_i = 1'b0;
  logic        busy_o, div0_o;
  logic [15:0] y_bo;
  logic [7:0]  r_bo;

  typedef struct {
    logic [15:0] y;
    logic [7:0]  r;
    logic        d;
    int          len;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] last_y = '0;
  logic [7:0]  last_r = '0;
  logic        last_d = 1'b0;

  seq_div dut (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .a_bi   (a_bi),
    .b_bi   (b_bi),
    .start_i(start_i),
    .busy_o (busy_o),
    .y_bo   (y_bo),
    .r_bo   (r_bo),
    .div0_o (div0_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: measures busy length and compares at each busy falling edge
  bit prev_busy = 1'b0;
  int blen = 0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      prev_busy = 1'b0;
      blen = 0;
    end else begin
      if (busy_o) begin
        if (!prev_busy) begin
          chk("hold_y", 32'(y_bo), 32'(last_y));
          chk("hold_r", 32'(r_bo), 32'(last_r));
          chk("hold_div0", 32'(div0_o), 32'(last_d));
        end
        blen++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          chk("unexpected_completion", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("y", 32'(y_bo), 32'(e.y));
          chk("r", 32'(r_bo), 32'(e.r));
          chk("div0", 32'(div0_o), 32'(e.d));
          chk("busy_len", blen, e.len);
          last_y = e.y;
          last_r = e.r;
          last_d = e.d;
        end
        blen = 0;
      end
      prev_busy = busy_o;
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy_o && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (busy_o) chk("idle_timeout", 1, 0);
  endtask

  task automatic op(input logic [15:0] a, input logic [7:0] b, input logic [15:0] y,
                    input logic [7:0] r, input logic d, input int len, input int poke);
    sb.push_back('{y, r, d, len});
    @(negedge clk);
    a_bi = a;
    b_bi = b;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    a_bi = 16'($urandom);
    b_bi = 8'($urandom);
    if (poke > 0) begin
      repeat (poke) @(negedge clk);
      a_bi = 16'd1;
      b_bi = 8'd1;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    wait_idle();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_y", 32'(y_bo), 0);
    chk("rst_r", 32'(r_bo), 0);
    chk("rst_div0", 32'(div0_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    op(16'd100, 8'd7, 16'd14, 8'd2, 1'b0, 16, 0);
    op(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 16, 0);
    op(16'd3, 8'd200, 16'd0, 8'd3, 1'b0, 16, 0);
    op(16'd5, 8'd0, 16'hFFFF, 8'h05, 1'b1, 1, 0);
    op(16'd9, 8'd3, 16'd3, 8'd0, 1'b0, 16, 0);
    for (int i = 1; i <= 15; i++)
      op(16'(i * i), 8'(i), 16'(i), 8'd0, 1'b0, 16, 0);
    op(16'd200, 8'd9, 16'd22, 8'd2, 1'b0, 16, 4);
    @(negedge clk);
    a_bi = 16'd1000;
    b_bi = 8'd10;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_y", 32'(y_bo), 0);
    chk("arst_r", 32'(r_bo), 0);
    chk("arst_div0", 32'(div0_o), 0);
    last_y = '0;
    last_r = '0;
    last_d = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op(16'd50, 8'd5, 16'd10, 8'd0, 1'b0, 16, 0);
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
